// File: rtl/kem_hash_sequencer.sv
// kem_hash_sequencer: runs H(rand_in), H(ek), G(msg||hek) in turn over one shared SHA3 engine.
// Optional KEM_EK_HASH_CACHE_EN adds ek_reuse to skip re-hashing an unchanged ek.
module kem_hash_sequencer #(
    parameter int KYBER_N = 256,
    parameter int EK_W    = 9472,
    parameter int LEN_W   = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [EK_W-1:0]      ek,
    input  logic [KYBER_N-1:0]   rand_in,
`ifdef KEM_EK_HASH_CACHE_EN
    input  logic                 ek_reuse,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [KYBER_N-1:0]   msg,
    output logic [KYBER_N-1:0]   coin,
    output logic [KYBER_N-1:0]   pre_k,
    output logic                 h_start,
    output logic                 h_mode,
    output logic [LEN_W-1:0]     h_len,
    output logic [EK_W-1:0]      h_in,
    input  logic [2*KYBER_N-1:0] h_out,
    input  logic                 h_valid
);
    typedef enum logic [2:0] {IDLE, ISS_M, WAIT_M, ISS_EK, WAIT_EK, ISS_G, WAIT_G, DONE} state_t;
    state_t state, state_nx;
    logic [KYBER_N-1:0] hek;
    logic skip_ek;

`ifdef KEM_EK_HASH_CACHE_EN
    logic hek_valid;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hek_valid <= 1'b0;
            skip_ek   <= 1'b0;
        end else begin
            if (state == IDLE && start) skip_ek <= ek_reuse && hek_valid;
            if (state == WAIT_EK && h_valid) hek_valid <= 1'b1;
        end
    end
`else
    assign skip_ek = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        busy     = state != IDLE;
        done     = state == DONE;
        h_start  = state == ISS_M || state == ISS_EK || state == ISS_G;
        case (state)
            IDLE:    state_nx = start ? ISS_M : IDLE;
            ISS_M:   state_nx = WAIT_M;
            WAIT_M:  state_nx = h_valid ? (skip_ek ? ISS_G : ISS_EK) : WAIT_M;
            ISS_EK:  state_nx = WAIT_EK;
            WAIT_EK: state_nx = h_valid ? ISS_G : WAIT_EK;
            ISS_G:   state_nx = WAIT_G;
            WAIT_G:  state_nx = h_valid ? DONE : WAIT_G;
            default: state_nx = IDLE;
        endcase
    end

    // Operands are loaded on the edge entering each ISS state so they are stable from h_start onward.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            msg    <= '0;
            coin   <= '0;
            pre_k  <= '0;
            hek    <= '0;
            h_mode <= 1'b0;
            h_len  <= '0;
            h_in   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    h_mode <= 1'b0;
                    h_len  <= LEN_W'(KYBER_N);
                    h_in   <= EK_W'(rand_in);
                end
                WAIT_M: if (h_valid) begin
                    msg    <= h_out[KYBER_N-1:0];
                    h_mode <= skip_ek;
                    h_len  <= skip_ek ? LEN_W'(2*KYBER_N) : LEN_W'(EK_W);
                    h_in   <= skip_ek ? EK_W'({hek, h_out[KYBER_N-1:0]}) : ek;
                end
                WAIT_EK: if (h_valid) begin
                    hek    <= h_out[KYBER_N-1:0];
                    h_mode <= 1'b1;
                    h_len  <= LEN_W'(2*KYBER_N);
                    h_in   <= EK_W'({h_out[KYBER_N-1:0], msg});
                end
                WAIT_G: if (h_valid) begin
                    pre_k  <= h_out[KYBER_N-1:0];
                    coin   <= h_out[2*KYBER_N-1:KYBER_N];
                    h_mode <= 1'b0;
                    h_len  <= '0;
                    h_in   <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_kem_hash_sequencer.sv
// tb_kem_hash_sequencer: directed table-driven bench with a fixed-latency stand-in hash engine.
module tb_kem_hash_sequencer;
    localparam int N  = 256;
    localparam int EW = 9472;
    localparam int LW = 14;

    logic clk = 0, rst = 0, start = 0;
    logic [EW-1:0] ek = '0;
    logic [N-1:0] rand_in = '0;
    logic busy, done, h_start, h_mode, h_valid;
    logic [N-1:0] msg, coin, pre_k;
    logic [LW-1:0] h_len;
    logic [EW-1:0] h_in;
    logic [2*N-1:0] h_out;
`ifdef KEM_EK_HASH_CACHE_EN
    logic ek_reuse = 0;
`endif

    kem_hash_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .ek(ek), .rand_in(rand_in),
`ifdef KEM_EK_HASH_CACHE_EN
        .ek_reuse(ek_reuse),
`endif
        .busy(busy), .done(done), .msg(msg), .coin(coin), .pre_k(pre_k),
        .h_start(h_start), .h_mode(h_mode), .h_len(h_len), .h_in(h_in),
        .h_out(h_out), .h_valid(h_valid)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // Stand-in digest: folds the whole operand so every input bit matters.
    function automatic logic [511:0] eng(input logic mode, input logic [LW-1:0] len, input logic [EW-1:0] din);
        logic [255:0] f = '0;
        for (int i = 0; i < EW / 256; i++) f ^= din[i*256 +: 256];
        f = {f[254:0], f[255]} ^ {242'd0, len} ^ {8{32'h9E3779B9}};
        return mode ? {f ^ {32{8'hA5}}, f} : {256'd0, f};
    endfunction

    function automatic logic [EW-1:0] mk_ek(input int s);
        logic [EW-1:0] e = '0;
        for (int i = 0; i < EW / 32; i++) e[i*32 +: 32] = (32'(s) * 32'h9E3779B9) ^ 32'(i);
        return e;
    endfunction

    int lat = 20;
    logic [9:0] cnt;
    logic [511:0] m_out, pend;
    logic hv_m, spur = 0;
    assign h_valid = hv_m | spur;
    assign h_out = spur ? {16{32'hDEADBEEF}} : m_out;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0; hv_m <= 1'b0; m_out <= '0; pend <= '0;
        end else begin
            hv_m <= 1'b0;
            if (h_start) begin
                cnt  <= 10'(lat - 1);
                pend <= eng(h_mode, h_len, h_in);
            end else if (cnt == 1) begin
                cnt <= '0; hv_m <= 1'b1; m_out <= pend;
            end else if (cnt > 1) cnt <= cnt - 1;
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int nhs, dcyc;
    int hcyc[3];
    logic [14:0] hml[3];
    logic [511:0] gin;
    logic hin_zero_done;

    task automatic run_seq(input logic [N-1:0] r, input logic [EW-1:0] e, input int l, input logic reuse);
        lat = l;
        @(negedge clk);
        rand_in = r; ek = e; start = 1;
`ifdef KEM_EK_HASH_CACHE_EN
        ek_reuse = reuse;
`endif
        nhs = 0; dcyc = -1; gin = '0; hin_zero_done = 0;
        for (int i = 0; i < 3; i++) begin hcyc[i] = -1; hml[i] = '0; end
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            start = 0;
            if (h_start) begin
                if (nhs < 3) begin hcyc[nhs] = n; hml[nhs] = {h_mode, h_len}; end
                if (h_mode) gin = h_in[511:0];
                nhs++;
            end
            if (done) begin dcyc = n; hin_zero_done = (h_in == '0); break; end
        end
        if (reuse) lat = l;
    endtask

    typedef struct {
        logic [N-1:0] r;
        int s;
        int l;
        int hs1, hs2, hs3, dc;
    } vec_t;
    vec_t tbl[3];

    logic [511:0] a, b, g;
    logic [N-1:0] s_msg, s_pre, s_coin;
    int cnt_hs, cnt_done, hs4;

    initial begin
        tbl[0] = '{r: 256'h1,  s: 1, l: 20, hs1: 1, hs2: 22, hs3: 43, dc: 64};
        tbl[1] = '{r: {8{32'hC0FFEE11}}, s: 7, l: 2, hs1: 1, hs2: 4, hs3: 7, dc: 10};
        tbl[2] = '{r: '1, s: 3, l: 7, hs1: 1, hs2: 9, hs3: 17, dc: 25};

        #1;
        chk("rst_busy", 512'(busy), 0);
        chk("rst_done", 512'(done), 0);
        chk("rst_hstart", 512'(h_start), 0);
        chk("rst_hin", 512'(|h_in), 0);
        chk("rst_outs", {msg, pre_k}, 0);
        @(negedge clk); rst = 1;

        foreach (tbl[k]) begin
            run_seq(tbl[k].r, mk_ek(tbl[k].s), tbl[k].l, 0);
            a = eng(0, LW'(256), EW'(tbl[k].r));
            b = eng(0, LW'(EW), mk_ek(tbl[k].s));
            g = eng(1, LW'(512), EW'({b[255:0], a[255:0]}));
            chk($sformatf("v%0d_nhs", k), 512'(nhs), 3);
            chk($sformatf("v%0d_hs1", k), 512'(hcyc[0]), 512'(tbl[k].hs1));
            chk($sformatf("v%0d_hs2", k), 512'(hcyc[1]), 512'(tbl[k].hs2));
            chk($sformatf("v%0d_hs3", k), 512'(hcyc[2]), 512'(tbl[k].hs3));
            chk($sformatf("v%0d_ml1", k), 512'(hml[0]), {497'd0, 1'b0, 14'd256});
            chk($sformatf("v%0d_ml2", k), 512'(hml[1]), {497'd0, 1'b0, 14'd9472});
            chk($sformatf("v%0d_ml3", k), 512'(hml[2]), {497'd0, 1'b1, 14'd512});
            chk($sformatf("v%0d_done", k), 512'(dcyc), 512'(tbl[k].dc));
            chk($sformatf("v%0d_gop", k), gin, {b[255:0], a[255:0]});
            chk($sformatf("v%0d_msg", k), 512'(msg), 512'(a[255:0]));
            chk($sformatf("v%0d_prek", k), 512'(pre_k), 512'(g[255:0]));
            chk($sformatf("v%0d_coin", k), 512'(coin), 512'(g[511:256]));
            chk($sformatf("v%0d_hin0", k), 512'(hin_zero_done), 1);
            @(negedge clk);
            chk($sformatf("v%0d_idle", k), 512'({busy, done}), 0);
        end

        // Spurious h_valid in DONE and then in IDLE
        run_seq(256'h5A, mk_ek(9), 3, 0);
        s_msg = msg; s_pre = pre_k; s_coin = coin;
        spur = 1; @(negedge clk); spur = 0;
        chk("spur_done_busy", 512'(busy), 0);
        chk("spur_done_outs", {s_pre, s_coin} ^ {pre_k, coin}, 0);
        spur = 1; @(negedge clk); spur = 0; @(negedge clk);
        chk("spur_idle_busy", 512'({busy, h_start}), 0);
        chk("spur_idle_outs", 512'(msg ^ s_msg) | {pre_k ^ s_pre, coin ^ s_coin}, 0);

        // start held high for 100 cycles
        lat = 20; cnt_hs = 0; cnt_done = 0; hs4 = -1;
        rand_in = 256'h77; ek = mk_ek(4); start = 1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (h_start) begin cnt_hs++; if (cnt_hs == 4) hs4 = n; end
            if (done) cnt_done++;
        end
        start = 0;
        chk("hold_nhs", 512'(cnt_hs), 5);
        chk("hold_ndone", 512'(cnt_done), 1);
        chk("hold_reaccept", 512'(hs4), 66);
        rst = 0; @(negedge clk); rst = 1;

        // Asynchronous reset during WAIT_EK
        lat = 20; rand_in = 256'h1234; ek = mk_ek(5); start = 1;
        for (int n = 1; n <= 27; n++) begin @(negedge clk); start = 0; end
        chk("pre_rst_msg_set", 512'(msg != '0), 1);
        #2 rst = 0; #1;
        chk("arst_flags", 512'({busy, h_start, done, h_mode}), 0);
        chk("arst_outs", 512'(msg) | {pre_k, coin}, 0);
        chk("arst_hbus", 512'({|h_in, h_len}), 0);
        @(negedge clk); rst = 1; cnt_done = 0;
        for (int n = 0; n < 30; n++) begin @(negedge clk); if (done) cnt_done++; end
        chk("arst_no_done", 512'(cnt_done), 0);
        run_seq(256'h1, mk_ek(1), 20, 0);
        a = eng(0, LW'(256), EW'(256'h1));
        chk("arst_fresh_done", 512'(dcyc), 64);
        chk("arst_fresh_msg", 512'(msg), 512'(a[255:0]));

`ifdef KEM_EK_HASH_CACHE_EN
        run_seq(256'h99, mk_ek(1), 20, 1);
        a = eng(0, LW'(256), EW'(256'h99));
        b = eng(0, LW'(EW), mk_ek(1));
        g = eng(1, LW'(512), EW'({b[255:0], a[255:0]}));
        chk("cache_nhs", 512'(nhs), 2);
        chk("cache_ml1", 512'(hml[0]), {497'd0, 1'b0, 14'd256});
        chk("cache_ml2", 512'(hml[1]), {497'd0, 1'b1, 14'd512});
        chk("cache_done", 512'(dcyc), 43);
        chk("cache_prek", 512'(pre_k), 512'(g[255:0]));
        ek_reuse = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
